// File: rtl/router_input_requester.sv
// Router input port: buffers flits, requests the decoded output port, and
// streams one whole packet per grant before releasing the request.
module router_input_requester #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned PORT_ID    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [15:0]       req_out,
    input  logic [15:0]       grant_in,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              err_grant_lost
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, SEND, RELEASE} state_t;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    state_t            state_q, state_d;
    logic [3:0]        dest_q, dest_d;
    logic [4:0]        remaining_q, remaining_d;
    logic [15:0]       req_q, req_d;
    logic              err_q, err_d;

    logic              fifo_empty;
    logic              fifo_full;
    logic [DATA_W-1:0] head;
    logic              grant_dest;
    logic              push;
    logic              pop;

    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == DEPTH_C);
        head       = mem_q[rd_ptr_q];
        grant_dest = grant_in[dest_q];
        push       = in_valid && !fifo_full;
        pop        = (state_q == SEND) && !fifo_empty && grant_dest;
    end

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_data;
        end
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        state_d     = state_q;
        dest_d      = dest_q;
        remaining_d = remaining_q;
        req_d       = req_q;
        err_d       = err_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                // Header is only peeked here; it leaves the FIFO as the first SEND pop.
                if (!fifo_empty) begin
                    dest_d      = head[3:0];
                    remaining_d = {1'b0, head[7:4]} + 5'd1;
                    req_d       = 16'd1 << head[3:0];
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (grant_dest) state_d = SEND;
            end
            SEND: begin
                if (!grant_dest) err_d = 1'b1;
                if (pop) begin
                    remaining_d = remaining_q - 5'd1;
                    if (remaining_q == 5'd1) begin
                        req_d   = '0;
                        state_d = RELEASE;
                    end
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= IDLE;
            dest_q      <= '0;
            remaining_q <= '0;
            req_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            dest_q      <= dest_d;
            remaining_q <= remaining_d;
            req_q       <= req_d;
            err_q       <= err_d;
        end
    end

    assign in_ready       = !fifo_full;
    assign req_out        = req_q;
    assign out_valid      = pop;
    assign out_data       = fifo_empty ? '0 : head;
    assign busy           = (state_q != IDLE);
    assign err_grant_lost = err_q;

    req_onehot_a: assert property (@(posedge clk) disable iff (reset) $onehot0(req_q))
        else $error("router_input_requester port %0d: multi-hot request", PORT_ID);

endmodule

// File: doc/router_input_requester.md
Name: router_input_requester

Overview:
Input-port controller for the 16x16 router and the requesting side of each output-port fixed-priority arbiter. It buffers incoming flits in a FIFO and decodes the header's destination. It raises a one-hot request toward that output's arbiter, waits for the grant, streams the whole packet, then drops the request so the arbiter can re-grant. One instance per input port; req_out[d] drives bit PORT_ID of output d's arbiter request vector, and grant_in[d] is that arbiter's grant bit PORT_ID.

Parameters:
DATA_W, 8, flit width; header layout [7:4] = payload length L (0..15), [3:0] = destination port.
FIFO_DEPTH, 16, input buffer depth in flits; power of two, minimum 2.
PORT_ID, 0, this input's index 0..15; only used for documentation and assertions.

Ports:
clk  input  1  clock, all logic on rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  upstream flit valid.
in_data  input  DATA_W  upstream flit.
in_ready  output  1  = !fifo_full; a flit is accepted when in_valid && in_ready.
req_out  output  16  one-hot request to output arbiters, registered.
grant_in  input  16  grant bits from the 16 output arbiters (registered on their side).
out_valid  output  1  flit presented to the switch this cycle.
out_data  output  DATA_W  flit to the switch (FIFO head).
busy  output  1  state != IDLE.
err_grant_lost  output  1  sticky: grant dropped while SEND with request held.

Behaviour:
- Reset, sampled at the clk edge, has priority over everything. FIFO is emptied. State = IDLE. Outputs: req_out=0, out_valid=0, out_data=0, busy=0, err_grant_lost=0, in_ready=1 after that edge. Reset mid-packet discards the packet and buffered flits; no request remains.
- FIFO: registered read/write pointers plus count. A push and a pop in the same cycle are both honoured; count is unchanged. A push while full is ignored, since in_ready=0. The pointers wrap modulo FIFO_DEPTH. out_data always shows the head entry, or 0 when empty.
- FSM states: IDLE, REQ, SEND, RELEASE.
- IDLE: if the FIFO is non-empty, latch dest=head[3:0] and remaining=head[7:4]+1 (header plus L payload flits; 5-bit counter). Then go to REQ and set req_out <= 1<<dest. The header stays in the FIFO.
- REQ: hold req_out. On an edge where grant_in[dest]=1, go to SEND. There is no timeout; lower-priority ports may wait indefinitely, and that is accepted behaviour. grant_in bits other than dest are ignored.
- SEND: out_valid = fifo_nonempty && grant_in[dest]. Pop on out_valid, and decrement remaining on pop.
  - An empty FIFO stalls with out_valid=0 while the request is held.
  - When the pop takes remaining from 1 to 0: req_out <= 0, go to RELEASE.
  - If grant_in[dest]=0 in SEND: set err_grant_lost (cleared only by reset), out_valid=0, keep the request, remain in SEND.
- RELEASE: req_out=0, out_valid=0 for exactly one cycle, which lets the arbiter clear its grant. Then go to IDLE.
- Minimum per-packet overhead: 3 non-transfer cycles (IDLE, REQ-with-grant-latency, RELEASE).
- A header-only packet (L=0) is legal: exactly one flit is transferred.
- The packet boundary is derived only from L; payload contents are never interpreted.
- Upstream may push continuously during SEND.

Test Plan:
- Reset: assert reset 2 cycles with in_valid=1 -> in_ready=1 after release; req_out=0, out_valid=0, busy=0, FIFO empty (no flit accepted during reset).
- Single packet: push header 0x25 then 2 payloads (0xA1, 0xA2); grant_in[5] rises 1 cycle after req_out[5] -> req_out=0x0020; out_data 0x25,0xA1,0xA2 on 3 consecutive out_valid cycles; req_out=0 next; RELEASE for 1 cycle, then IDLE.
- Contention: hold grant_in[5]=0 for 10 cycles -> req_out stays 0x0020, out_valid=0, busy=1; grant then asserted -> transfer proceeds as above.
- Underflow stall: header 0x3C accepted, payloads trickle 1 every 4 cycles -> out_valid pulses only when the FIFO is non-empty; request held until the 4th flit; total 4 pops.
- Full FIFO: push 17 flits without grant, FIFO_DEPTH=16 -> in_ready=0 after 16 accepted; 17th ignored; after one pop, in_ready=1; simultaneous push+pop keeps count.
- Grant lost: drop grant_in[dest] mid-SEND -> err_grant_lost=1 (sticky), out_valid=0; restore grant -> remaining flits sent; error stays 1 until reset.
